// File: rtl/bus_mem_responder_pkg.sv
// Shared types and constants for the CPU data-bus memory responder.
// Holds the bus direction encoding, FSM state encoding and captured-request layout.
package bus_mem_responder_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] address;
    logic        rw;
    logic [31:0] wdata;
  } req_t;

  // Full-width compare so that aliasing high address bits never hit the array.
  function automatic logic addr_in_range(input logic [31:0] address,
                                         input int unsigned depth);
    return address < 32'(depth);
  endfunction

endpackage

// File: rtl/bus_mem_responder_mem_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read.
// Contents survive reset; only the write enable gates updates.
module bus_mem_responder_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: no reset on the array; resetting storage would force flops instead of RAM.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_mem_responder.sv
// Word-addressed memory target for the CPU data bus: captures a request, waits
// LATENCY cycles, then commits the write or returns read data with a one-cycle ack.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] address,
  input  logic        rw,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t      state_q;
  state_t      state_d;
  req_t        cap_q;
  logic [3:0]  cnt_q;
  logic        err_q;
  logic        in_rng;
  logic        mem_we;
  logic [31:0] mem_rdata;

  assign in_rng = addr_in_range(cap_q.address, DEPTH);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture registers and latency counter; fields stay frozen until the next IDLE capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cap_q <= '0;
      cnt_q <= '0;
    end else if (state_q == IDLE && req) begin
      cap_q <= '{address: address, rw: rw, wdata: wdata};
      cnt_q <= LAT;
    end else if (state_q == WAIT) begin
      if (!req) begin
        cnt_q <= '0;
      end else if (cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (state_q == RESP && !in_rng) begin
      err_q <= 1'b1;
    end
  end

  // err is visible in the RESP cycle itself, then held by err_q.
  always_comb begin
    ack    = (state_q == RESP);
    busy   = (state_q != IDLE);
    err    = err_q | (ack & ~in_rng);
    rdata  = '0;
    mem_we = 1'b0;
    if (ack && in_rng) begin
      if (cap_q.rw == RW_READ) begin
        rdata = mem_rdata;
      end else begin
        mem_we = reset;
      end
    end
  end

  bus_mem_responder_mem_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clock(clock),
    .we   (mem_we),
    .waddr(cap_q.address[AW-1:0]),
    .wdata(cap_q.wdata),
    .raddr(cap_q.address[AW-1:0]),
    .rdata(mem_rdata)
  );

endmodule
